// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: DEPTH x DATA_WIDTH register file with one byte-masked write port and two registered read ports.
// Optional macro REG_FILE_WR_BYPASS_EN forwards same-cycle merged write data to colliding reads.
module reg_file_2r1w #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    WrEn,
    input  logic [ADDR_WIDTH-1:0]   WrAddr,
    input  logic [DATA_WIDTH-1:0]   WrData,
    input  logic [DATA_WIDTH/8-1:0] WrMask,
    input  logic                    RdEnA,
    input  logic [ADDR_WIDTH-1:0]   RdAddrA,
    output logic [DATA_WIDTH-1:0]   RdDataA,
    output logic                    RdValidA,
    input  logic                    RdEnB,
    input  logic [ADDR_WIDTH-1:0]   RdAddrB,
    output logic [DATA_WIDTH-1:0]   RdDataB,
    output logic                    RdValidB,
    output logic                    AddrErr
);
    localparam int unsigned         NBYTES   = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] LP_DEPTH = DEPTH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data_a;
    logic [DATA_WIDTH-1:0] r_rd_data_b;
    logic                  r_rd_valid_a;
    logic                  r_rd_valid_b;
    logic                  r_addr_err;

    logic                  w_wr_in;
    logic                  w_rd_in_a;
    logic                  w_rd_in_b;
    logic                  w_wr_ok;
    logic [DATA_WIDTH-1:0] w_wr_merged;
    logic [DATA_WIDTH-1:0] w_rd_a;
    logic [DATA_WIDTH-1:0] w_rd_b;

    // Range checks use one extra bit so DEPTH == 2**ADDR_WIDTH is representable.
    assign w_wr_in   = ({1'b0, WrAddr}  < LP_DEPTH);
    assign w_rd_in_a = ({1'b0, RdAddrA} < LP_DEPTH);
    assign w_rd_in_b = ({1'b0, RdAddrB} < LP_DEPTH);
    assign w_wr_ok   = WrEn && w_wr_in;

    always_comb begin
        w_wr_merged = r_mem[WrAddr];
        for (int unsigned b = 0; b < NBYTES; b++) begin
            if (WrMask[b]) begin
                w_wr_merged[8*b +: 8] = WrData[8*b +: 8];
            end
        end
    end

    always_comb begin
        w_rd_a = r_mem[RdAddrA];
        w_rd_b = r_mem[RdAddrB];
`ifdef REG_FILE_WR_BYPASS_EN
        if (w_wr_ok && (WrAddr == RdAddrA)) begin
            w_rd_a = w_wr_merged;
        end
        if (w_wr_ok && (WrAddr == RdAddrB)) begin
            w_rd_b = w_wr_merged;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_data_a  <= '0;
            r_rd_data_b  <= '0;
            r_rd_valid_a <= 1'b0;
            r_rd_valid_b <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_mem[WrAddr] <= w_wr_merged;
            end

            r_rd_valid_a <= RdEnA;
            if (RdEnA) begin
                r_rd_data_a <= w_rd_in_a ? w_rd_a : '0;
            end

            r_rd_valid_b <= RdEnB;
            if (RdEnB) begin
                r_rd_data_b <= w_rd_in_b ? w_rd_b : '0;
            end

            r_addr_err <= (WrEn  && !w_wr_in)
                       || (RdEnA && !w_rd_in_a)
                       || (RdEnB && !w_rd_in_b);
        end
    end

    assign RdDataA  = r_rd_data_a;
    assign RdDataB  = r_rd_data_b;
    assign RdValidA = r_rd_valid_a;
    assign RdValidB = r_rd_valid_b;
    assign AddrErr  = r_addr_err;

endmodule
